// File: rtl/bcd_serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses for the serial BCD adder.
// The master drives the request side; the sequencer is the slave.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic [4*DIGITS-1:0] A;
  logic [4*DIGITS-1:0] B;
  logic                Ci;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] S;
  logic                Co;
  logic                err;

  modport master (
    output start, A, B, Ci,
    input  busy, done, S, Co, err
  );

  modport slave (
    input  start, A, B, Ci,
    output busy, done, S, Co, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one single-digit add/correct stage,
// one digit per clock from the least-significant digit, with a registered decimal carry.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);
  localparam int              W        = 4 * DIGITS;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One decimal digit add: {carry_out, corrected_digit}.
  function automatic logic [4:0] bcd_digit_add(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c
  );
    logic [4:0] raw;
    logic [4:0] adj;
    logic [4:0] res;
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      res = {1'b1, adj[3:0]};
    end else begin
      res = {1'b0, raw[3:0]};
    end
    return res;
  endfunction

  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    a_s;
  logic [W-1:0]    b_r;
  logic [W-1:0]    b_s;
  logic [W-1:0]    s_r;
  logic [W-1:0]    s_s;
  logic [IDXW-1:0] idx_r;
  logic [IDXW-1:0] idx_s;
  logic            carry_r;
  logic            carry_s;
  logic            co_r;
  logic            co_s;
  logic            err_r;
  logic            err_s;
  logic            busy_r;
  logic            busy_s;
  logic            done_r;
  logic            done_s;

  logic [IDXW+1:0] bit_base_s;
  logic [3:0]      a_dig_s;
  logic [3:0]      b_dig_s;
  logic [4:0]      add_res_s;
  logic            dig_bad_s;

  // Select the current operand digits and run them through the digit stage.
  always_comb begin
    bit_base_s = {idx_r, 2'b00};
    a_dig_s    = a_r[bit_base_s +: 4];
    b_dig_s    = b_r[bit_base_s +: 4];
    add_res_s  = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
    dig_bad_s  = digit_invalid(a_dig_s) | digit_invalid(b_dig_s);
  end

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    s_s     = s_r;
    idx_s   = idx_r;
    carry_s = carry_r;
    co_s    = co_r;
    err_s   = err_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          a_s     = bus.A;
          b_s     = bus.B;
          carry_s = bus.Ci;
          idx_s   = {IDXW{1'b0}};
          s_s     = {W{1'b0}};
          co_s    = 1'b0;
          err_s   = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_ADD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        s_s[bit_base_s +: 4] = add_res_s[3:0];
        carry_s              = add_res_s[4];
        if (dig_bad_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (idx_r == LAST_IDX) begin
          co_s    = add_res_s[4];
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r + IDXW'(1);
          busy_s  = 1'b1;
          state_s = ST_ADD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {IDXW{1'b0}};
        carry_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      s_r     <= {W{1'b0}};
      idx_r   <= {IDXW{1'b0}};
      carry_r <= 1'b0;
      co_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      s_r     <= s_s;
      idx_r   <= idx_s;
      carry_r <= carry_s;
      co_r    <= co_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.Co   = co_r;
  assign bus.err  = err_r;

  bcd_serial_add_ctrl_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r)
  );
endmodule

// Handshake properties of the sequencer outputs.
module bcd_serial_add_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_busy_ends_done: assert property (@(posedge clk) disable iff (rst) $fell(busy) |-> done);
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed vector table, multi-cycle corner sequences,
// and random operands checked against a decimal/digit-rule reference model.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal arithmetic for valid operands, digit rule when any digit exceeds 9.
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic er);
    int da, db, tot, c, r, d;
    er = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) er = 1'b1;
    end
    s = '0;
    if (!er) begin
      da = 0;
      db = 0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        da = da * 10 + int'(a[4*k +: 4]);
        db = db * 10 + int'(b[4*k +: 4]);
      end
      tot = da + db + int'(ci);
      co  = (tot >= 10 ** DIGITS);
      tot = tot % (10 ** DIGITS);
      for (int k = 0; k < DIGITS; k++) begin
        s[4*k +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(ci);
      for (int k = 0; k < DIGITS; k++) begin
        r = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + c;
        if (r > 9) begin
          d = (r + 6) % 16;
          c = 1;
        end else begin
          d = r;
          c = 0;
        end
        s[4*k +: 4] = 4'(d);
      end
      co = (c != 0);
    end
  endtask

  // Wait (bounded) for the done pulse; sampled 1 time unit after each rising edge.
  task automatic wait_done(input string nm, output int busy_cycles);
    busy_cycles = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) return;
      if (bus.busy) busy_cycles++;
    end
    chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] es, input logic eco, input logic eerr,
                       input string nm);
    int bc;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, " busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    wait_done(nm, bc);
    chk({nm, " busy_cycles"}, 32'(bc + 1), 32'(DIGITS));
    chk({nm, " done_not_busy"}, {30'd0, bus.done, bus.busy}, 32'd2);
    chk({nm, " S"}, {16'd0, bus.S}, {16'd0, es});
    chk({nm, " Co"}, {31'd0, bus.Co}, {31'd0, eco});
    chk({nm, " err"}, {31'd0, bus.err}, {31'd0, eerr});
    @(posedge clk);
    #1;
    chk({nm, " done_one_cycle"}, {30'd0, bus.done, bus.busy}, 32'd0);
    chk({nm, " S_hold"}, {16'd0, bus.S}, {16'd0, es});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, rs;
    logic         rci, rco, rer;
    int           bc;

    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Ci    = 1'b0;

    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    tbl[3] = '{16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1};
    tbl[4] = '{16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0F0F, 16'h0000, 1'b0, 16'h1515, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset S", {16'd0, bus.S}, 32'd0);
    chk("reset Co_err", {30'd0, bus.Co, bus.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].err,
            $sformatf("vec%0d", i));
    end

    // start pulsed again mid-operation must be ignored
    @(negedge clk);
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Ci = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.A = 16'h4444; bus.B = 16'h4444; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start", bc);
    chk("ignore_start S", {16'd0, bus.S}, 32'h3333);
    chk("ignore_start Co_err", {30'd0, bus.Co, bus.err}, 32'd0);
    @(posedge clk);
    #1;

    // asynchronous reset after the second digit
    @(negedge clk);
    bus.A = 16'h000A; bus.B = 16'h0000; bus.Ci = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset err", {31'd0, bus.err}, 32'd1);
    chk("pre_reset S", {16'd0, bus.S}, 32'h0010);
    rst = 1'b1;
    #1;
    chk("async_reset busy", {31'd0, bus.busy}, 32'd0);
    chk("async_reset S", {16'd0, bus.S}, 32'd0);
    chk("async_reset Co_err", {30'd0, bus.Co, bus.err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, "after_reset");

    // start held high: back-to-back operations with one idle cycle between
    @(negedge clk);
    bus.A = 16'h0001; bus.B = 16'h0001; bus.Ci = 1'b0; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done($sformatf("held%0d", k), bc);
      chk($sformatf("held%0d S", k), {16'd0, bus.S}, 32'h0002);
      @(posedge clk);
      #1;
      chk($sformatf("held%0d idle_gap", k), {30'd0, bus.busy, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("held%0d restart", k), {31'd0, bus.busy}, 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("held_drain", bc);
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < DIGITS; k++) begin
        ra[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      rci = 1'($urandom_range(0, 1));
      ref_add(ra, rb, rci, rs, rco, rer);
      do_op(ra, rb, rci, rs, rco, rer, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
